// File: rtl/pp_pipeline_accel_pkg.sv
// rtl/pp_pipeline_accel_pkg.sv - shared state encoding and width defaults for the pipeline accel blocks
package pp_pipeline_accel_pkg;

  // Default width of trip counts and iteration counters
  localparam int CNT_W_DEFAULT = 16;

  // Loop-trip sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pp_pipeline_accel_loop_trip_sequencer.sv
// rtl/pp_pipeline_accel_loop_trip_sequencer.sv - issues trip_count iterations to a pipelined body and tracks retirement
module pp_pipeline_accel_loop_trip_sequencer
  import pp_pipeline_accel_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  input  logic             ap_continue,
  input  logic [CNT_W-1:0] trip_count,
  output logic             body_start,
  input  logic             body_ready,
  input  logic             body_done,
  output logic             body_loop_init,
  output logic [CNT_W-1:0] iter_index
);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_trip;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  logic w_in_idle;
  logic w_in_run;
  logic w_in_drain;
  logic w_zero_trip;
  logic w_issue;
  logic w_last_issue;
  logic w_retire;
  logic w_all_retired;

  assign w_in_idle     = (r_state == ST_IDLE);
  assign w_in_run      = (r_state == ST_RUN);
  assign w_in_drain    = (r_state == ST_DRAIN);
  assign w_zero_trip   = (trip_count == '0);
  assign w_issue       = w_in_run && body_ready;
  assign w_last_issue  = w_issue && (r_issue_cnt == (r_trip - CNT_W'(1)));
  // Retirements beyond the trip count are dropped so ret_cnt never passes trip_r
  assign w_retire      = body_done && (w_in_run || w_in_drain) && (r_ret_cnt != r_trip);
  assign w_all_retired = (r_ret_cnt == r_trip);

  // Control FSM with issue/retire counters; a start in IDLE re-arms both counters
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= ST_IDLE;
      r_trip      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_retire) begin
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_trip      <= trip_count;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_state     <= w_zero_trip ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // Always pass through DRAIN, even if the last retirement already arrived
          if (w_last_issue) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_all_retired) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ap_continue) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decode registered state only, so reset clears them without a clock
  assign ap_idle        = w_in_idle;
  assign ap_done        = (r_state == ST_DONE);
  assign body_start     = w_in_run;
  assign body_loop_init = w_in_run && (r_issue_cnt == '0);
  assign iter_index     = w_in_run ? r_issue_cnt : '0;

  // ap_ready is the one combinational output: the final accepted issue, or a zero-trip start
  assign ap_ready = w_last_issue || (w_in_idle && ap_start && w_zero_trip);

endmodule

// File: tb/tb_pp_pipeline_accel_loop_trip_sequencer.sv
// tb/tb_pp_pipeline_accel_loop_trip_sequencer.sv - scoreboard bench for the loop-trip sequencer
module tb_pp_pipeline_accel_loop_trip_sequencer;

  localparam int CNT_W = 16;

  localparam int K_OFFER = 0;
  localparam int K_READY = 1;
  localparam int K_DRISE = 2;
  localparam int K_DFALL = 3;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             ap_start = 1'b0;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_continue = 1'b0;
  logic [CNT_W-1:0] trip_count = '0;
  logic             body_start;
  logic             body_ready = 1'b0;
  logic             body_done = 1'b0;
  logic             body_loop_init;
  logic [CNT_W-1:0] iter_index;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  t0;
  logic prev_done = 1'b0;

  pp_pipeline_accel_loop_trip_sequencer #(.CNT_W(CNT_W)) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_continue    (ap_continue),
    .trip_count     (trip_count),
    .body_start     (body_start),
    .body_ready     (body_ready),
    .body_done      (body_done),
    .body_loop_init (body_loop_init),
    .iter_index     (iter_index)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic int off(input int iter, input int init, input int rdy);
    return iter | (init << 16) | (rdy << 17);
  endfunction

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d val=%h required=none", kind, cyc, val);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        n_bad++;
        $display("FAIL event actual kind=%0d cyc=%0d val=%h required kind=%0d cyc=%0d val=%h",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: every observable DUT event is matched against the next expected entry
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      prev_done = 1'b0;
    end else begin
      if (body_start) observe(K_OFFER, off(int'(iter_index), int'(body_loop_init), int'(body_ready)));
      if (ap_ready) observe(K_READY, 0);
      if (ap_done && !prev_done) observe(K_DRISE, 0);
      if (!ap_done && prev_done) observe(K_DFALL, 0);
      prev_done = ap_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk("rst_idle", int'(ap_idle), 1);
    step();
    ap_rst = 1'b0;
    step();
    chk("rst_ready", int'(ap_ready), 0);
    chk("rst_done", int'(ap_done), 0);
    chk("rst_body_start", int'(body_start), 0);
    chk("rst_loop_init", int'(body_loop_init), 0);
    chk("rst_iter", int'(iter_index), 0);

    // trip=4, ready/done held high
    step();
    t0 = cyc;
    ap_start = 1'b1; trip_count = 16'd4; body_ready = 1'b1; body_done = 1'b1;
    for (int k = 0; k < 4; k++) push(K_OFFER, t0 + 1 + k, off(k, (k == 0) ? 1 : 0, 1));
    push(K_READY, t0 + 4, 0);
    push(K_DRISE, t0 + 6, 0);
    push(K_DFALL, t0 + 9, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      ap_start = 1'b0;
      ap_continue = (i == 8);
      if (i == 7) chk("t1_done_held", int'(ap_done), 1);
    end
    ap_continue = 1'b0; body_ready = 1'b0; body_done = 1'b0;
    chk("t1_idle", int'(ap_idle), 1);

    // trip=0
    step();
    t0 = cyc;
    ap_start = 1'b1; trip_count = 16'd0;
    push(K_READY, t0, 0);
    push(K_DRISE, t0 + 1, 0);
    push(K_DFALL, t0 + 2, 0);
    step();
    ap_start = 1'b0; ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    chk("t2_idle", int'(ap_idle), 1);

    // trip=3, toggling ready, retirements 5 cycles after each issue, long hold in DONE
    step();
    t0 = cyc;
    ap_start = 1'b1; trip_count = 16'd3; body_ready = 1'b0;
    push(K_OFFER, t0 + 1, off(0, 1, 1));
    push(K_OFFER, t0 + 2, off(1, 0, 0));
    push(K_OFFER, t0 + 3, off(1, 0, 1));
    push(K_OFFER, t0 + 4, off(2, 0, 0));
    push(K_OFFER, t0 + 5, off(2, 0, 1));
    push(K_READY, t0 + 5, 0);
    push(K_DRISE, t0 + 12, 0);
    push(K_DFALL, t0 + 23, 0);
    for (int i = 1; i <= 23; i++) begin
      step();
      body_ready  = (i <= 5) && (i % 2 == 1);
      body_done   = (i == 6) || (i == 8) || (i == 10);
      ap_start    = (i >= 12) && (i <= 21);
      ap_continue = (i == 22);
      if (i == 11) chk("t3_drain_no_done", int'(ap_done), 0);
      if (i == 21) chk("t3_done_held", int'(ap_done), 1);
    end
    chk("t3_idle", int'(ap_idle), 1);

    // reset in RUN at issue_cnt=2, then trip=2
    step();
    t0 = cyc;
    ap_start = 1'b1; trip_count = 16'd5; body_ready = 1'b1; body_done = 1'b0;
    push(K_OFFER, t0 + 1, off(0, 1, 1));
    push(K_OFFER, t0 + 2, off(1, 0, 1));
    step();
    ap_start = 1'b0;
    step();
    step();
    chk("t4_iter_before_rst", int'(iter_index), 2);
    #1;
    ap_rst = 1'b1; body_done = 1'b1;
    #1;
    chk("t4_rst_idle", int'(ap_idle), 1);
    chk("t4_rst_ready", int'(ap_ready), 0);
    chk("t4_rst_done", int'(ap_done), 0);
    chk("t4_rst_body_start", int'(body_start), 0);
    chk("t4_rst_loop_init", int'(body_loop_init), 0);
    chk("t4_rst_iter", int'(iter_index), 0);
    step();
    step();
    ap_rst = 1'b0;
    step();
    step();
    body_done = 1'b0; body_ready = 1'b0;
    chk("t4_idle_after_rst", int'(ap_idle), 1);

    step();
    t0 = cyc;
    ap_start = 1'b1; trip_count = 16'd2;
    push(K_OFFER, t0 + 1, off(0, 1, 1));
    push(K_OFFER, t0 + 2, off(1, 0, 1));
    push(K_READY, t0 + 2, 0);
    push(K_DRISE, t0 + 5, 0);
    push(K_DFALL, t0 + 7, 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      ap_start    = 1'b0;
      body_ready  = (i <= 2);
      body_done   = (i == 2) || (i == 3);
      ap_continue = (i == 6);
    end
    ap_continue = 1'b0;
    chk("t5_idle", int'(ap_idle), 1);

    for (int i = 0; i < 4; i++) step();
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
